status_register_stack: RTL and testbench
========================================

Name: status_register_stack

Overview:
- Parametrised successor to the single-level CPU status (NZCV) register.
- Holds the live flag register with a per-flag write mask.
- Adds a LIFO of saved status words for exception entry/return: push saves the live flags, pop restores them.
- Sits between the execute-stage flag generator and the condition-check logic; the exception controller drives push/pop.

Parameters:
- FLAG_W, 4, number of status flags (bit 3..0 = N,Z,C,V at default).
- DEPTH, 4, number of saved-status entries in the stack (>=1).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  system clock; all state updates on the falling edge.
- rst  input  1  asynchronous, active-low reset.
- s  input  1  live-flag update enable.
- flag_mask  input  FLAG_W  per-flag write enable; bit i=1 lets status_bits_in[i] update when s=1.
- status_bits_in  input  FLAG_W  new flag values from the ALU.
- push  input  1  save live flags onto the stack (exception entry).
- pop  input  1  restore live flags from the top of the stack (exception return).
- err_clr  input  1  clears the sticky error flags.
- status_bits_out  output  FLAG_W  live flags.
- saved_top  output  FLAG_W  top-of-stack entry; 0 when empty.
- depth  output  CNT_W  number of valid stack entries.
- full  output  1  depth==DEPTH.
- empty  output  1  depth==0.
- overflow_err  output  1  sticky; a push was attempted while full.
- underflow_err  output  1  sticky; a pop was attempted while empty.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - status_bits_out, depth, all stack entries, overflow_err and underflow_err to 0.
  - Result: empty=1, full=0, saved_top=0.
  - Reset asserted mid-sequence discards all saved entries immediately.
- All registered state updates on the negedge of clk. Outputs are stable for rising-edge consumers one half-cycle after the update.
- Masked update (s=1, no effective pop): status_bits_out <= (status_bits_in & flag_mask) | (status_bits_out & ~flag_mask).
- With s=0 and no effective pop, the live flags hold.
- Push only (push=1, pop=0):
  - Not full: the entry at index depth <= current (pre-update) status_bits_out; depth+1. A simultaneous s update applies to the live register in the same edge.
  - Full: stack and depth unchanged, overflow_err <= 1, s update still applies.
- Pop only (pop=1, push=0):
  - Not empty: status_bits_out <= entry[depth-1]; depth-1. The restore wins over s (s ignored that edge).
  - Empty: no stack or live change from the pop, underflow_err <= 1, s update applies normally.
- Push and pop together:
  - Not empty: swap. status_bits_out <= top entry, top entry <= pre-update live flags, depth unchanged, s ignored.
  - Empty: underflow_err <= 1, stack unchanged, s applies.
- Error flags:
  - err_clr=1 clears both error flags.
  - If an error event occurs in the same edge as err_clr, the set wins.
- saved_top, full, empty are combinational from depth and the stack array.
- depth never exceeds DEPTH or wraps below 0.

Test Plan:
- Reset and masked write: rst pulse low -> all outputs 0, empty=1. Then s=1, flag_mask=4'b1010, status_bits_in=4'b1111 -> status_bits_out=4'b1010. Then s=1, mask=4'b0001, in=4'b0000 -> output stays 4'b1010.
- Push/pop restore: live=4'b1010; push with s=1, mask=4'hF, in=4'b0101 -> saved_top=4'b1010, live=4'b0101, depth=1. Then pop with s=1, in=4'b1111 -> live=4'b1010, depth=0, empty=1.
- Overflow: DEPTH=4; five pushes with live values 1,2,3,4,5 -> depth=4, full=1, overflow_err=1, saved_top=4. Four pops -> live=1, empty=1.
- Underflow and sticky clear: pop while empty with s=1, mask=4'hF, in=4'b0011 -> underflow_err=1, live=4'b0011, depth=0. err_clr alone -> underflow_err=0. pop+err_clr while empty -> underflow_err=1.
- Swap: stack top=4'b0110, live=4'b1001; push=pop=1 -> live=4'b0110, saved_top=4'b1001, depth unchanged.
- Async reset mid-operation: depth=3, assert rst between clock edges -> depth=0, outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/status_register_stack_if.sv
// Purpose : bundles the flag-update, exception push/pop and status outputs of status_register_stack.
// Latency : n/a (wiring only); the stack registers its state on the falling clock edge.
// Backpress: none; push/pop are single-cycle strobes with sticky error reporting instead of stalls.
//
// Ports (master = execute stage + exception controller, slave = status_register_stack):
//   s, flag_mask, status_bits_in   live-flag masked update request
//   push, pop, err_clr             exception entry/return and sticky-error clear
//   status_bits_out, saved_top     live flags and top-of-stack entry
//   depth, full, empty             stack occupancy
//   overflow_err, underflow_err    sticky misuse indications
interface status_register_stack_if #(
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic              s;
  logic [FLAG_W-1:0] flag_mask;
  logic [FLAG_W-1:0] status_bits_in;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [FLAG_W-1:0] status_bits_out;
  logic [FLAG_W-1:0] saved_top;
  logic [CNT_W-1:0]  depth;
  logic              full;
  logic              empty;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output s, flag_mask, status_bits_in, push, pop, err_clr,
    input  status_bits_out, saved_top, depth, full, empty, overflow_err, underflow_err
  );

  modport slave (
    input  s, flag_mask, status_bits_in, push, pop, err_clr,
    output status_bits_out, saved_top, depth, full, empty, overflow_err, underflow_err
  );
endinterface

// File: rtl/status_register_stack.sv
// Purpose : live NZCV-style flag register with per-flag write mask plus a LIFO of saved status words.
// Latency : all state updates on the falling clk edge; outputs settle for rising-edge consumers half a cycle later.
// Backpress: none; a push while full or pop while empty is dropped and latched in a sticky error flag.
//
// Ports:
//   clk  system clock (state updates on negedge)
//   rst  asynchronous active-low reset
//   sr   status_register_stack_if.slave (update/push/pop inputs, live/saved/occupancy/error outputs)
module status_register_stack #(
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  status_register_stack_if.slave sr
);

  logic [FLAG_W-1:0] live_q;
  logic [FLAG_W-1:0] stack_q [DEPTH];
  logic [CNT_W-1:0]  depth_q;
  logic              ovf_q;
  logic              unf_q;

  logic              full_w;
  logic              empty_w;
  logic [FLAG_W-1:0] top_w;
  logic [FLAG_W-1:0] masked_w;

  // Decoded operations for this edge.
  logic push_only_ok;  // push lands in a free slot
  logic pop_only_ok;   // pop restores and shrinks the stack
  logic swap_ok;       // push+pop on a non-empty stack exchanges live and top
  logic restore;       // live register is loaded from the top entry (pop or swap)
  logic ovf_evt;
  logic unf_evt;

  assign full_w  = (depth_q == CNT_W'(DEPTH));
  assign empty_w = (depth_q == '0);

  // Top entry lives at index depth-1; decode by compare so no index ever
  // exceeds the array bounds, and an empty stack reads as zero.
  always_comb begin
    top_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == CNT_W'(i + 1)) top_w = stack_q[i];
    end
  end

  assign masked_w = (sr.status_bits_in & sr.flag_mask) | (live_q & ~sr.flag_mask);

  assign push_only_ok = sr.push & ~sr.pop & ~full_w;
  assign pop_only_ok  = sr.pop & ~sr.push & ~empty_w;
  assign swap_ok      = sr.push & sr.pop & ~empty_w;
  assign restore      = sr.pop & ~empty_w;
  // A pop on an empty stack is an underflow even when paired with a push.
  assign ovf_evt      = sr.push & ~sr.pop & full_w;
  assign unf_evt      = sr.pop & empty_w;

  // Live flags: a restore overrides the ALU update for that edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      live_q <= '0;
    end else if (restore) begin
      live_q <= top_w;
    end else if (sr.s) begin
      live_q <= masked_w;
    end
  end

  // Stack entries: push writes slot depth, swap overwrites slot depth-1.
  // Both capture the pre-update live value.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_only_ok && depth_q == CNT_W'(i)) begin
          stack_q[i] <= live_q;
        end else if (swap_ok && depth_q == CNT_W'(i + 1)) begin
          stack_q[i] <= live_q;
        end
      end
    end
  end

  // Occupancy saturates by construction: growth is gated by full, shrink by empty.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      depth_q <= '0;
    end else if (push_only_ok) begin
      depth_q <= depth_q + CNT_W'(1);
    end else if (pop_only_ok) begin
      depth_q <= depth_q - CNT_W'(1);
    end
  end

  // Sticky errors: a new event in the same edge as err_clr keeps the flag set.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_evt | (ovf_q & ~sr.err_clr);
      unf_q <= unf_evt | (unf_q & ~sr.err_clr);
    end
  end

  assign sr.status_bits_out = live_q;
  assign sr.saved_top       = top_w;
  assign sr.depth           = depth_q;
  assign sr.full            = full_w;
  assign sr.empty           = empty_w;
  assign sr.overflow_err    = ovf_q;
  assign sr.underflow_err   = unf_q;

endmodule

// File: tb/tb_status_register_stack.sv
// Purpose : directed self-checking bench for status_register_stack (DEPTH=4, FLAG_W=4).
// Latency : inputs driven after posedge, DUT updates on negedge, outputs sampled 1ns after negedge.
// Backpress: none.
module tb_status_register_stack;

  localparam int FLAG_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  status_register_stack_if #(.FLAG_W(FLAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) sr_if ();

  status_register_stack #(.FLAG_W(FLAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .sr  (sr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One operation per cycle: drive after posedge, sample just after the negedge update.
  task automatic step(input logic s_i, input logic [3:0] m_i, input logic [3:0] d_i,
                      input logic push_i, input logic pop_i, input logic clr_i);
    @(posedge clk);
    sr_if.s              = s_i;
    sr_if.flag_mask      = m_i;
    sr_if.status_bits_in = d_i;
    sr_if.push           = push_i;
    sr_if.pop            = pop_i;
    sr_if.err_clr        = clr_i;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sr_if.s              = 1'b0;
    sr_if.flag_mask      = '0;
    sr_if.status_bits_in = '0;
    sr_if.push           = 1'b0;
    sr_if.pop            = 1'b0;
    sr_if.err_clr        = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #12;
    checks++; if (sr_if.status_bits_out !== 4'b0000) begin errors++; $display("FAIL rst_live got=%b exp=0000", sr_if.status_bits_out); end
    checks++; if (sr_if.depth !== 3'd0) begin errors++; $display("FAIL rst_depth got=%0d exp=0", sr_if.depth); end
    checks++; if (sr_if.empty !== 1'b1 || sr_if.full !== 1'b0) begin errors++; $display("FAIL rst_empty_full got=%b%b exp=10", sr_if.empty, sr_if.full); end
    checks++; if (sr_if.saved_top !== 4'b0000) begin errors++; $display("FAIL rst_top got=%b exp=0000", sr_if.saved_top); end
    checks++; if (sr_if.overflow_err !== 1'b0 || sr_if.underflow_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b%b exp=00", sr_if.overflow_err, sr_if.underflow_err); end
    @(posedge clk);
    rst = 1'b1;
  endtask

  task automatic test_masked_write();
    step(1'b1, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0);
    checks++; if (sr_if.status_bits_out !== 4'b1010) begin errors++; $display("FAIL mask_set got=%b exp=1010", sr_if.status_bits_out); end
    step(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    checks++; if (sr_if.status_bits_out !== 4'b1010) begin errors++; $display("FAIL mask_keep got=%b exp=1010", sr_if.status_bits_out); end
    // s=0 must hold even with all mask bits set.
    step(1'b0, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0);
    checks++; if (sr_if.status_bits_out !== 4'b1010) begin errors++; $display("FAIL s_off_hold got=%b exp=1010", sr_if.status_bits_out); end
    step(1'b1, 4'b0110, 4'b0100, 1'b0, 1'b0, 1'b0);
    checks++; if (sr_if.status_bits_out !== 4'b1100) begin errors++; $display("FAIL mask_mix got=%b exp=1100", sr_if.status_bits_out); end
    step(1'b1, 4'b1111, 4'b1010, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_push_pop();
    step(1'b1, 4'hF, 4'b0101, 1'b1, 1'b0, 1'b0);
    checks++; if (sr_if.saved_top !== 4'b1010) begin errors++; $display("FAIL push_top got=%b exp=1010", sr_if.saved_top); end
    checks++; if (sr_if.status_bits_out !== 4'b0101) begin errors++; $display("FAIL push_live got=%b exp=0101", sr_if.status_bits_out); end
    checks++; if (sr_if.depth !== 3'd1 || sr_if.empty !== 1'b0) begin errors++; $display("FAIL push_depth got=%0d/%b exp=1/0", sr_if.depth, sr_if.empty); end
    step(1'b1, 4'hF, 4'b1111, 1'b0, 1'b1, 1'b0);
    checks++; if (sr_if.status_bits_out !== 4'b1010) begin errors++; $display("FAIL pop_live got=%b exp=1010", sr_if.status_bits_out); end
    checks++; if (sr_if.depth !== 3'd0 || sr_if.empty !== 1'b1) begin errors++; $display("FAIL pop_depth got=%0d/%b exp=0/1", sr_if.depth, sr_if.empty); end
    checks++; if (sr_if.saved_top !== 4'b0000) begin errors++; $display("FAIL pop_top got=%b exp=0000", sr_if.saved_top); end
  endtask

  task automatic test_overflow();
    logic [3:0] exp_live;
    step(1'b1, 4'hF, 4'd1, 1'b0, 1'b0, 1'b0);
    // Four pushes save 1..4 while the ALU loads 2..5.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 4'hF, 4'(i + 1), 1'b1, 1'b0, 1'b0);
      checks++; if (sr_if.depth !== 3'(i)) begin errors++; $display("FAIL ovf_fill_depth%0d got=%0d exp=%0d", i, sr_if.depth, i); end
    end
    checks++; if (sr_if.overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", sr_if.overflow_err); end
    // Fifth push (live=5) while full: dropped, but the s update still lands.
    step(1'b1, 4'hF, 4'd7, 1'b1, 1'b0, 1'b0);
    checks++; if (sr_if.depth !== 3'd4 || sr_if.full !== 1'b1) begin errors++; $display("FAIL ovf_depth got=%0d/%b exp=4/1", sr_if.depth, sr_if.full); end
    checks++; if (sr_if.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", sr_if.overflow_err); end
    checks++; if (sr_if.saved_top !== 4'd4) begin errors++; $display("FAIL ovf_top got=%0d exp=4", sr_if.saved_top); end
    checks++; if (sr_if.status_bits_out !== 4'd7) begin errors++; $display("FAIL ovf_live got=%0d exp=7", sr_if.status_bits_out); end
    for (int i = 0; i < 4; i++) begin
      exp_live = 4'(4 - i);
      step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      checks++; if (sr_if.status_bits_out !== exp_live) begin errors++; $display("FAIL ovf_pop%0d got=%0d exp=%0d", i, sr_if.status_bits_out, exp_live); end
    end
    checks++; if (sr_if.empty !== 1'b1 || sr_if.depth !== 3'd0) begin errors++; $display("FAIL ovf_drain got=%b/%0d exp=1/0", sr_if.empty, sr_if.depth); end
    checks++; if (sr_if.overflow_err !== 1'b1 || sr_if.underflow_err !== 1'b0) begin errors++; $display("FAIL ovf_sticky got=%b%b exp=10", sr_if.overflow_err, sr_if.underflow_err); end
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (sr_if.overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", sr_if.overflow_err); end
  endtask

  task automatic test_underflow();
    step(1'b1, 4'hF, 4'b0011, 1'b0, 1'b1, 1'b0);
    checks++; if (sr_if.underflow_err !== 1'b1) begin errors++; $display("FAIL unf_flag got=%b exp=1", sr_if.underflow_err); end
    checks++; if (sr_if.status_bits_out !== 4'b0011) begin errors++; $display("FAIL unf_live got=%b exp=0011", sr_if.status_bits_out); end
    checks++; if (sr_if.depth !== 3'd0) begin errors++; $display("FAIL unf_depth got=%0d exp=0", sr_if.depth); end
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (sr_if.underflow_err !== 1'b0) begin errors++; $display("FAIL unf_clr got=%b exp=0", sr_if.underflow_err); end
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    checks++; if (sr_if.underflow_err !== 1'b1) begin errors++; $display("FAIL unf_set_wins got=%b exp=1", sr_if.underflow_err); end
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    // push+pop on an empty stack is an underflow; the stack stays empty and s applies.
    step(1'b1, 4'hF, 4'b1110, 1'b1, 1'b1, 1'b0);
    checks++; if (sr_if.underflow_err !== 1'b1 || sr_if.overflow_err !== 1'b0) begin errors++; $display("FAIL swap_empty_err got=%b%b exp=01", sr_if.overflow_err, sr_if.underflow_err); end
    checks++; if (sr_if.depth !== 3'd0 || sr_if.status_bits_out !== 4'b1110) begin errors++; $display("FAIL swap_empty_state got=%0d/%b exp=0/1110", sr_if.depth, sr_if.status_bits_out); end
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_swap();
    step(1'b1, 4'hF, 4'b0110, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hF, 4'b1001, 1'b1, 1'b0, 1'b0);
    checks++; if (sr_if.saved_top !== 4'b0110 || sr_if.status_bits_out !== 4'b1001) begin errors++; $display("FAIL swap_setup got=%b/%b exp=0110/1001", sr_if.saved_top, sr_if.status_bits_out); end
    // s is ignored during a swap.
    step(1'b1, 4'hF, 4'b0000, 1'b1, 1'b1, 1'b0);
    checks++; if (sr_if.status_bits_out !== 4'b0110) begin errors++; $display("FAIL swap_live got=%b exp=0110", sr_if.status_bits_out); end
    checks++; if (sr_if.saved_top !== 4'b1001) begin errors++; $display("FAIL swap_top got=%b exp=1001", sr_if.saved_top); end
    checks++; if (sr_if.depth !== 3'd1 || sr_if.underflow_err !== 1'b0) begin errors++; $display("FAIL swap_depth got=%0d/%b exp=1/0", sr_if.depth, sr_if.underflow_err); end
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (sr_if.status_bits_out !== 4'b1001 || sr_if.empty !== 1'b1) begin errors++; $display("FAIL swap_pop got=%b/%b exp=1001/1", sr_if.status_bits_out, sr_if.empty); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 4'hF, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'hF, 4'b0010, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'hF, 4'b0011, 1'b1, 1'b0, 1'b0);
    checks++; if (sr_if.depth !== 3'd3 || sr_if.saved_top !== 4'b0010) begin errors++; $display("FAIL arst_pre got=%0d/%b exp=3/0010", sr_if.depth, sr_if.saved_top); end
    idle_inputs();
    // Now 1ns after a negedge; the next edge of either polarity is 4ns away.
    #1 rst = 1'b0;
    #1;
    checks++; if (sr_if.depth !== 3'd0 || sr_if.empty !== 1'b1) begin errors++; $display("FAIL arst_depth got=%0d/%b exp=0/1", sr_if.depth, sr_if.empty); end
    checks++; if (sr_if.status_bits_out !== 4'b0000 || sr_if.saved_top !== 4'b0000) begin errors++; $display("FAIL arst_out got=%b/%b exp=0000/0000", sr_if.status_bits_out, sr_if.saved_top); end
    @(posedge clk);
    rst = 1'b1;
    // Saved entries must be gone: a pop now is an underflow.
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (sr_if.underflow_err !== 1'b1 || sr_if.status_bits_out !== 4'b0000) begin errors++; $display("FAIL arst_pop got=%b/%b exp=1/0000", sr_if.underflow_err, sr_if.status_bits_out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_inputs();
    test_reset();
    test_masked_write();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_swap();
    test_async_reset();
    idle_inputs();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
